ram_sync_param: RTL and testbench



---
 rtl/ram_sync_param_if.sv | 27 ++
 rtl/ram_sync_param.sv | 92 +++++++++
 tb/tb_ram_sync_param.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_sync_param_if.sv
// Bus bundle for ram_sync_param.
//   in        write data                  (master -> slave)
//   addr      word address                (master -> slave)
//   write     write enable                (master -> slave)
//   read      read enable                 (master -> slave)
//   clear     zero-the-array request      (master -> slave)
//   out       registered read data        (slave -> master)
//   out_valid out holds last cycle's read (slave -> master)
//   busy      clear sweep in progress     (slave -> master)
interface ram_sync_param_if #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 5
);
    logic [WIDTH-1:0]     in;
    logic [ADDR_BITS-1:0] addr;
    logic                 write;
    logic                 read;
    logic                 clear;
    logic [WIDTH-1:0]     out;
    logic                 out_valid;
    logic                 busy;

    modport master (output in, addr, write, read, clear,
                    input  out, out_valid, busy);
    modport slave  (input  in, addr, write, read, clear,
                    output out, out_valid, busy);
endinterface

// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with registered read, read-valid
// strobe and a hardware clear sweep that zeroes every word after reset or on
// request.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    ram_sync_param_if.slave: in/addr/write/read/clear in,
//          out/out_valid/busy out
module ram_sync_param #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_sync_param_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t               state, state_nxt;
    logic [ADDR_BITS-1:0] clr_ptr;
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [WIDTH-1:0]     out_q;
    logic                 vld_q;

    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [WIDTH-1:0]     mem_wdata;
    logic                 rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_CLEAR;
        else        state <= state_nxt;
    end

    // Next state plus the single memory write port. The sweep owns the port
    // while clearing; clear in READY suppresses the user write and read.
    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_waddr = bus.addr;
        mem_wdata = bus.in;
        rd_en     = 1'b0;
        case (state)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                mem_wdata = '0;
                if (clr_ptr == '1) state_nxt = S_READY;
            end
            S_READY: begin
                if (bus.clear) begin
                    state_nxt = S_CLEAR;
                end else begin
                    mem_we = bus.write;
                    rd_en  = bus.read;
                end
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    // Array has no reset; the sweep provides the zero contents.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Read data is sampled before the same-edge write lands: read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (state == S_CLEAR) begin
                // Wraps back to 0 on the last word, ready for the next sweep.
                clr_ptr <= clr_ptr + ADDR_BITS'(1);
            end else if (bus.clear) begin
                clr_ptr <= '0;
                out_q   <= '0;
            end else if (rd_en) begin
                out_q <= mem[bus.addr];
                vld_q <= 1'b1;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = vld_q;
    assign bus.busy      = (state == S_CLEAR);
endmodule

// File: tb/tb_ram_sync_param.sv
module tb_ram_sync_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_sync_param_if #(.WIDTH(16), .ADDR_BITS(5)) ia ();
    ram_sync_param_if #(.WIDTH(8),  .ADDR_BITS(3)) ib ();

    ram_sync_param #(.WIDTH(16), .ADDR_BITS(5)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    ram_sync_param #(.WIDTH(8),  .ADDR_BITS(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    int checks = 0;
    int failures = 0;

    // Reference model: array contents, remaining busy cycles, expected outputs.
    logic [15:0] ma [32];
    int          bl_a;
    logic [15:0] eo_a;
    logic        ev_a;
    logic [7:0]  mb [8];
    int          bl_b;
    logic [7:0]  eo_b;
    logic        ev_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bl_a = 32; eo_a = '0; ev_a = 1'b0;
        bl_b = 8;  eo_b = '0; ev_b = 1'b0;
        for (int i = 0; i < 32; i++) ma[i] = '0;
        for (int i = 0; i < 8; i++)  mb[i] = '0;
    endtask

    task automatic idle();
        ia.in = '0; ia.addr = '0; ia.write = 0; ia.read = 0; ia.clear = 0;
        ib.in = '0; ib.addr = '0; ib.write = 0; ib.read = 0; ib.clear = 0;
    endtask

    // One clock: capture inputs, advance the model, compare all outputs.
    task automatic tick();
        logic aw, ar, ac, bw, br, bc;
        logic [4:0] aa; logic [15:0] ad;
        logic [2:0] ba; logic [7:0]  bd;
        aw = ia.write; ar = ia.read; ac = ia.clear; aa = ia.addr; ad = ia.in;
        bw = ib.write; br = ib.read; bc = ib.clear; ba = ib.addr; bd = ib.in;
        @(posedge clk);
        if (bl_a > 0) begin
            bl_a--; ev_a = 1'b0;
        end else if (ac) begin
            bl_a = 32; eo_a = '0; ev_a = 1'b0;
            for (int i = 0; i < 32; i++) ma[i] = '0;
        end else begin
            ev_a = ar;
            if (ar) eo_a = ma[aa];
            if (aw) ma[aa] = ad;
        end
        if (bl_b > 0) begin
            bl_b--; ev_b = 1'b0;
        end else if (bc) begin
            bl_b = 8; eo_b = '0; ev_b = 1'b0;
            for (int i = 0; i < 8; i++) mb[i] = '0;
        end else begin
            ev_b = br;
            if (br) eo_b = mb[ba];
            if (bw) mb[ba] = bd;
        end
        #1;
        check("a_out",   32'(ia.out),       32'(eo_a));
        check("a_valid", 32'(ia.out_valid), 32'(ev_a));
        check("a_busy",  32'(ia.busy),      32'(bl_a > 0));
        check("b_out",   32'(ib.out),       32'(eo_b));
        check("b_valid", 32'(ib.out_valid), 32'(ev_b));
        check("b_busy",  32'(ib.busy),      32'(bl_b > 0));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_a_busy",  32'(ia.busy), 32'd1);
        check("rst_a_out",   32'(ia.out), 32'd0);
        check("rst_a_valid", 32'(ia.out_valid), 32'd0);
        check("rst_b_busy",  32'(ib.busy), 32'd1);
        check("rst_b_out",   32'(ib.out), 32'd0);
        check("rst_b_valid", 32'(ib.out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Counts cycles with busy high; bounded so a stuck busy still finishes.
    task automatic sweep_count(input int exp_a, input int exp_b);
        int ca, cb;
        ca = 0; cb = 0;
        for (int n = 0; n < 100 && (ia.busy || ib.busy); n++) begin
            if (ia.busy) ca++;
            if (ib.busy) cb++;
            tick();
        end
        check("sweep_len_a", 32'(ca), 32'(exp_a));
        check("sweep_len_b", 32'(cb), 32'(exp_b));
    endtask

    initial begin
        idle();
        model_reset();
        #2;
        // Reset values while held in reset.
        check("init_a_busy", 32'(ia.busy), 32'd1);
        check("init_a_out",  32'(ia.out), 32'd0);
        do_reset();
        sweep_count(32, 8);

        // Every address reads zero after the sweep.
        for (int i = 0; i < 32; i++) begin
            ia.read = 1; ia.addr = 5'(i);
            ib.read = 1; ib.addr = 3'(i);
            tick();
            check("zero_a", 32'(ia.out), 32'd0);
        end
        idle();

        // Write then read back, then read idle holds out.
        ia.write = 1; ia.addr = 7; ia.in = 16'hBEEF;
        ib.write = 1; ib.addr = 7; ib.in = 8'hBE;
        tick();
        idle();
        ia.read = 1; ia.addr = 7; ib.read = 1; ib.addr = 7;
        tick();
        check("beef_a",   32'(ia.out), 32'hBEEF);
        check("beef_a_v", 32'(ia.out_valid), 32'd1);
        check("be_b",     32'(ib.out), 32'hBE);
        idle();
        tick();
        check("hold_a_v", 32'(ia.out_valid), 32'd0);
        check("hold_a",   32'(ia.out), 32'hBEEF);
        check("hold_b",   32'(ib.out), 32'hBE);

        // Read-first on same-address read+write.
        ia.write = 1; ia.addr = 3; ia.in = 16'h1111;
        tick();
        ia.in = 16'h2222; ia.read = 1;
        tick();
        check("rf_old", 32'(ia.out), 32'h1111);
        ia.write = 0;
        tick();
        check("rf_new", 32'(ia.out), 32'h2222);
        idle();

        // Fill, then clear colliding with a write to addr 0.
        for (int i = 0; i < 32; i++) begin
            ia.write = 1; ia.addr = 5'(i); ia.in = 16'(i) ^ 16'hA5A5;
            tick();
        end
        ia.addr = 0; ia.in = 16'hFFFF; ia.clear = 1;
        tick();
        idle();
        check("clr_out", 32'(ia.out), 32'd0);
        sweep_count(32, 0);
        for (int i = 0; i < 32; i++) begin
            ia.read = 1; ia.addr = 5'(i);
            tick();
            check("clr_zero", 32'(ia.out), 32'd0);
        end
        idle();

        // Accesses during the sweep are dropped.
        ia.write = 1; ia.addr = 5; ia.in = 16'h5555;
        tick();
        ia.clear = 1; ia.write = 0;
        tick();
        ia.clear = 0;
        for (int i = 0; i < 4; i++) begin
            ia.write = 1; ia.read = 1; ia.addr = 5; ia.in = 16'h7777; ia.clear = 1;
            tick();
            check("busy_no_valid", 32'(ia.out_valid), 32'd0);
        end
        idle();
        sweep_count(28, 0);
        ia.read = 1; ia.addr = 5;
        tick();
        check("busy_ignored", 32'(ia.out), 32'd0);
        idle();

        // Reset in the middle of a sweep restarts it from word 0.
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        do_reset();
        sweep_count(32, 8);

        // Randomized traffic on both instances.
        for (int n = 0; n < 800; n++) begin
            ia.write = 1'($urandom_range(0, 1)); ia.read = 1'($urandom_range(0, 1));
            ia.clear = ($urandom_range(0, 59) == 0); ia.addr = 5'($urandom); ia.in = 16'($urandom);
            ib.write = 1'($urandom_range(0, 1)); ib.read = 1'($urandom_range(0, 1));
            ib.clear = ($urandom_range(0, 39) == 0); ib.addr = 3'($urandom); ib.in = 8'($urandom);
            tick();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
